// File: rtl/ddr_downsample_ctrl.sv
// ddr_downsample_ctrl: reads a source image over a we/re + ready memory port,
// averages each 2x2 block and writes one rounded pixel per block at DST_BASE.
module ddr_downsample_ctrl #(
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256,
  parameter int SRC_BASE = 0,
  parameter int DST_BASE = 65536,
  parameter int TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready_we,
  input  logic        mem_ready_re
);

  localparam int BW = IMG_W / 2;
  localparam int BH = IMG_H / 2;
  localparam int CW = (BW > 1) ? $clog2(BW) : 1;
  localparam int RW = (BH > 1) ? $clog2(BH) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(BW - 1);
  localparam logic [RW-1:0] R_LAST = RW'(BH - 1);
  localparam logic [18:0]   SRC_A  = 19'(SRC_BASE);
  localparam logic [18:0]   DST_A  = 19'(DST_BASE);
  localparam logic [18:0]   ROW_A  = 19'(IMG_W);
  localparam logic [18:0]   BW_A   = 19'(BW);
  localparam logic [9:0]    TO_CNT = 10'(TIMEOUT);

  // Handshake: mem_re / mem_we are single-cycle requests; mem_addr (and
  // mem_wdata for writes) hold unchanged until the matching one-cycle ready
  // pulse is seen in the wait state. Ready pulses of the wrong type or outside
  // a wait state are ignored.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WR_ISSUE = 3'd3,
    WR_WAIT  = 3'd4,
    NEXT     = 3'd5,
    DONE     = 3'd6,
    ERR      = 3'd7
  } state_t;

  state_t          state, state_n;
  logic [RW-1:0]   r, r_n;
  logic [CW-1:0]   c, c_n;
  logic [1:0]      p, p_n;
  logic [9:0]      acc, acc_n;
  logic [9:0]      wait_cnt, wait_cnt_n;
  logic            err_q, err_n;

  logic [18:0]     r_ext, c_ext, blk_base, rd_addr, wr_addr;
  logic [9:0]      wait_inc;
  logic [7:0]      avg;

  assign r_ext    = 19'(r);
  assign c_ext    = 19'(c);
  assign blk_base = SRC_A + ((r_ext << 1) * ROW_A) + (c_ext << 1);
  assign rd_addr  = blk_base + (p[1] ? ROW_A : 19'd0) + {18'd0, p[0]};
  assign wr_addr  = DST_A + (r_ext * BW_A) + c_ext;
  assign wait_inc = wait_cnt + 10'd1;
  // acc tops out at 1020, so the rounding add cannot overflow 10 bits.
  assign avg      = 8'((acc + 10'd2) >> 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      r        <= '0;
      c        <= '0;
      p        <= '0;
      acc      <= '0;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      r        <= r_n;
      c        <= c_n;
      p        <= p_n;
      acc      <= acc_n;
      wait_cnt <= wait_cnt_n;
      err_q    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    r_n        = r;
    c_n        = c;
    p_n        = p;
    acc_n      = acc;
    wait_cnt_n = wait_cnt;
    err_n      = err_q;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RD_ISSUE;
          err_n   = 1'b0;
          r_n     = '0;
          c_n     = '0;
          p_n     = '0;
          acc_n   = '0;
        end
      end
      RD_ISSUE: begin
        state_n    = RD_WAIT;
        wait_cnt_n = '0;
      end
      RD_WAIT: begin
        if (mem_ready_re) begin
          acc_n = acc + {2'b00, mem_rdata};
          if (p == 2'd3) begin
            state_n = WR_ISSUE;
          end else begin
            p_n     = p + 2'd1;
            state_n = RD_ISSUE;
          end
        end else if (wait_inc == TO_CNT) begin
          state_n = ERR;
          err_n   = 1'b1;
        end else begin
          wait_cnt_n = wait_inc;
        end
      end
      WR_ISSUE: begin
        state_n    = WR_WAIT;
        wait_cnt_n = '0;
      end
      WR_WAIT: begin
        if (mem_ready_we) begin
          acc_n   = '0;
          p_n     = '0;
          state_n = NEXT;
        end else if (wait_inc == TO_CNT) begin
          state_n = ERR;
          err_n   = 1'b1;
        end else begin
          wait_cnt_n = wait_inc;
        end
      end
      NEXT: begin
        if (r == R_LAST && c == C_LAST) begin
          state_n = DONE;
        end else begin
          state_n = RD_ISSUE;
          if (c == C_LAST) begin
            c_n = '0;
            r_n = r + RW'(1);
          end else begin
            c_n = c + CW'(1);
          end
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      RD_ISSUE: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = rd_addr;
      end
      RD_WAIT: begin
        busy     = 1'b1;
        mem_addr = rd_addr;
      end
      WR_ISSUE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = avg;
      end
      WR_WAIT: begin
        busy      = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = avg;
      end
      NEXT:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  assign error = err_q;

endmodule

// File: tb/tb_ddr_downsample_ctrl.sv
// Bench for ddr_downsample_ctrl: a small memory with programmable ack delay,
// an expected-read/expected-write scoreboard built from 2x2 block averages.
`timescale 1ns/1ps
module tb_ddr_downsample_ctrl;

  localparam int IMG_W    = 4;
  localparam int IMG_H    = 4;
  localparam int SRC_BASE = 0;
  localparam int DST_BASE = 16;
  localparam int TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy, done, error;
  logic [18:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata;
  logic        mem_ready_we, mem_ready_re;

  ddr_downsample_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .SRC_BASE(SRC_BASE),
    .DST_BASE(DST_BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .error(error),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .mem_ready_we(mem_ready_we), .mem_ready_re(mem_ready_re)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [0:63];
  logic [18:0] rd_exp_q[$];
  logic [26:0] wr_exp_q[$];

  bit          resp_en = 1'b1;
  bit          stray_en = 1'b0;
  int          dly_min = 1, dly_max = 1;
  bit          pend_rd = 1'b0, pend_wr = 1'b0;
  int          cnt_rd = 0, cnt_wr = 0;
  logic [18:0] a_rd = '0, a_wr = '0;
  logic [7:0]  d_wr = '0;
  int          wr_acks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model and per-cycle checker, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      mem_ready_re = 1'b0;
      mem_ready_we = 1'b0;
      mem_rdata    = 8'($urandom);
      chk("we_re_exclusive", 32'(mem_we & mem_re), 32'd0);
      if (pend_rd) begin
        chk("rd_addr_stable", 32'(mem_addr), 32'(a_rd));
        cnt_rd = cnt_rd - 1;
        if (cnt_rd == 0) begin
          mem_ready_re = 1'b1;
          mem_rdata    = mem[a_rd[5:0]];
          pend_rd      = 1'b0;
        end
      end
      if (pend_wr) begin
        chk("wr_addr_stable", 32'({mem_addr, mem_wdata}), 32'({a_wr, d_wr}));
        cnt_wr = cnt_wr - 1;
        if (cnt_wr == 0) begin
          mem_ready_we     = 1'b1;
          mem[a_wr[5:0]]   = d_wr;
          wr_acks          = wr_acks + 1;
          pend_wr          = 1'b0;
        end
      end
      if (mem_re) begin
        if (rd_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: read at 0x%0h with none expected", mem_addr);
        end else begin
          chk("rd_addr", 32'(mem_addr), 32'(rd_exp_q.pop_front()));
        end
        if (resp_en) begin
          pend_rd = 1'b1;
          a_rd    = mem_addr;
          cnt_rd  = $urandom_range(dly_max, dly_min);
        end
      end
      if (mem_we) begin
        if (wr_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: write 0x%0h to 0x%0h with none expected", mem_wdata, mem_addr);
        end else begin
          chk("wr_addr_data", 32'({mem_addr, mem_wdata}), 32'(wr_exp_q.pop_front()));
        end
        pend_wr = 1'b1;
        a_wr    = mem_addr;
        d_wr    = mem_wdata;
        cnt_wr  = $urandom_range(dly_max, dly_min);
      end
      if (stray_en && $urandom_range(5, 0) == 0) begin
        if (!pend_rd && !mem_ready_re) mem_ready_re = 1'b1;
        else if (!pend_wr && !mem_ready_we) mem_ready_we = 1'b1;
      end
    end
  end

  // Reference: per block, four reads in raster order of the 2x2 window and one
  // write of the rounded mean at DST_BASE + block index.
  task automatic build_exp();
    for (int r = 0; r < IMG_H / 2; r++) begin
      for (int c = 0; c < IMG_W / 2; c++) begin
        int base, sum, a;
        base = SRC_BASE + 2 * r * IMG_W + 2 * c;
        sum  = 0;
        for (int q = 0; q < 4; q++) begin
          a = base + ((q >= 2) ? IMG_W : 0) + (q % 2);
          rd_exp_q.push_back(19'(a));
          sum += int'(mem[a]);
        end
        wr_exp_q.push_back({19'(DST_BASE + r * (IMG_W / 2) + c), 8'((sum + 2) / 4)});
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < IMG_W * IMG_H; i++) mem[SRC_BASE + i] = 8'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic run_frame(input int dmin, input int dmax, input bit stray,
                           input bit extra_start, input int exp_lat);
    int n, ndone, done_n;
    build_exp();
    dly_min  = dmin;
    dly_max  = dmax;
    stray_en = stray;
    wr_acks  = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1; ndone = 0; done_n = 0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("error_clear_on_start", 32'(error), 32'd0);
    while (n < 400 && (ndone == 0 || n < done_n + 4)) begin
      start = (extra_start && n == 12);
      @(negedge clk); n++;
      if (done) begin
        ndone++;
        if (ndone == 1) done_n = n;
        chk("busy_low_with_done", 32'(busy), 32'd0);
      end else if (ndone == 0) begin
        chk("busy_in_frame", 32'(busy), 32'd1);
      end else begin
        chk("busy_low_after_done", 32'(busy), 32'd0);
      end
    end
    start = 1'b0;
    stray_en = 1'b0;
    chk("done_pulses", 32'(ndone), 32'd1);
    if (exp_lat > 0) chk("frame_latency", 32'(done_n), 32'(exp_lat));
    chk("write_acks", 32'(wr_acks), 32'd4);
    chk("rd_queue_drained", 32'(rd_exp_q.size()), 32'd0);
    chk("wr_queue_drained", 32'(wr_exp_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    bit found;
    start = 1'b0;
    mem_rdata = '0; mem_ready_re = 1'b0; mem_ready_we = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i < 16 ? i : 0);
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    // Ramp image, 3-cycle acks: 21 cycles per block.
    run_frame(3, 3, 1'b0, 1'b0, 85);
    chk("ramp_dst16", 32'(mem[16]), 32'd3);
    chk("ramp_dst17", 32'(mem[17]), 32'd5);
    chk("ramp_dst18", 32'(mem[18]), 32'd11);
    chk("ramp_dst19", 32'(mem[19]), 32'd13);

    // Rounding and accumulator width, fastest acks: 11 cycles per block.
    mem[0] = 8'd1; mem[1] = 8'd1; mem[4] = 8'd1; mem[5] = 8'd2;
    mem[10] = 8'd255; mem[11] = 8'd255; mem[14] = 8'd255; mem[15] = 8'd254;
    run_frame(1, 1, 1'b1, 1'b0, 45);
    chk("round_low", 32'(mem[16]), 32'd1);
    chk("round_high", 32'(mem[19]), 32'd255);

    // Random images, random delays, stray acks, extra start while busy.
    for (int f = 0; f < 6; f++) begin
      fill_random();
      run_frame(1, $urandom_range(6, 1), 1'b1, (f % 2) == 1, 0);
    end

    // Timeout: reads never acknowledged.
    resp_en = 1'b0;
    rd_exp_q.push_back(19'(SRC_BASE));
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 1;
    chk("timeout_issue", 32'(mem_re), 32'd1);
    while (!error && n < 100) begin
      @(negedge clk); n++;
    end
    chk("timeout_cycle", 32'(n), 32'd17);
    chk("timeout_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    chk("error_sticky", 32'(error), 32'd1);
    chk("error_idle_busy", 32'(busy), 32'd0);
    chk("timeout_rd_queue", 32'(rd_exp_q.size()), 32'd0);
    resp_en = 1'b1;
    fill_random();
    run_frame(1, 4, 1'b0, 1'b0, 0);

    // Asynchronous reset while waiting on a read of the third block.
    fill_random();
    build_exp();
    dly_min = 3; dly_max = 3; wr_acks = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 1'b0;
    n = 0;
    while (!found && n < 300) begin
      if (wr_acks == 2 && mem_re) found = 1'b1;
      else begin
        @(negedge clk); n++;
      end
    end
    chk("reached_block2", 32'(found), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("midrst");
    rd_exp_q.delete();
    wr_exp_q.delete();
    pend_rd = 1'b0; pend_wr = 1'b0;
    mem_ready_re = 1'b0; mem_ready_we = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    run_frame(2, 4, 1'b1, 1'b0, 0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
